id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 105 ++++++++++
 tb/tb_id_ex_reg.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the 5-stage MIPS-style core.
// Captures decoded control, ALU op selection, operands, immediate, register
// specifiers and PC+4 from ID and presents them to EX one cycle later.
// stall holds the stage, flush (or an invalid ID slot) inserts a bubble whose
// control fields are zeroed while the data fields still load.
// Optional feature: define ID_EX_BUBBLE_CNT_EN to add a saturating 16-bit
// bubble_cnt output counting every bubble loaded into EX.
module id_ex_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [5:0]  id_ctrl,
  input  logic [1:0]  id_ALUOp,
  input  logic [5:0]  id_funct,
  input  logic [31:0] id_rd1,
  input  logic [31:0] id_rd2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_pc4,
  output logic        ex_valid,
  output logic [5:0]  ex_ctrl,
  output logic [1:0]  ex_ALUOp,
  output logic [5:0]  ex_funct,
  output logic [31:0] ex_rd1,
  output logic [31:0] ex_rd2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [15:0] bubble_cnt,
`endif
  output logic [31:0] ex_pc4
);

  // A flush always wins over a stall, so the stage advances whenever either
  // flush is set or the hazard unit is not holding it.
  logic load_en;
  // Bubble: explicit flush, or an empty ID slot arriving on a load edge.
  logic bubble;

  assign load_en = flush | ~stall;
  assign bubble  = flush | (~stall & ~id_valid);

  // Data fields follow ID on every advancing edge, bubble or not; downstream
  // ignores them when ex_valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_funct <= 6'd0;
      ex_rd1   <= 32'd0;
      ex_rd2   <= 32'd0;
      ex_imm   <= 32'd0;
      ex_pc4   <= 32'd0;
    end else if (load_en) begin
      ex_funct <= id_funct;
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
      ex_pc4   <= id_pc4;
    end
  end

  // Control fields and register specifiers are zeroed on a bubble so that
  // no write-enable or forwarding match can fire from an empty slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= 6'd0;
      ex_ALUOp <= 2'd0;
      ex_rs    <= 5'd0;
      ex_rt    <= 5'd0;
      ex_rd    <= 5'd0;
    end else if (bubble) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= 6'd0;
      ex_ALUOp <= 2'd0;
      ex_rs    <= 5'd0;
      ex_rt    <= 5'd0;
      ex_rd    <= 5'd0;
    end else if (load_en) begin
      ex_valid <= 1'b1;
      ex_ctrl  <= id_ctrl;
      ex_ALUOp <= id_ALUOp;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  // Count bubbles entering EX, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= 16'd0;
    end else if (bubble && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Testbench for id_ex_reg: directed hazard scenarios plus random traffic,
// checked by a queue-based scoreboard against a behavioural model.
// Define ID_EX_BUBBLE_CNT_EN to also exercise the bubble counter.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [5:0]  ctrl;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } stage_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   stall = 1'b0;
  logic   flush = 1'b0;
  stage_t idv = '0;
  stage_t actual;

  logic        ex_valid;
  logic [5:0]  ex_ctrl;
  logic [1:0]  ex_ALUOp;
  logic [5:0]  ex_funct;
  logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_rd;

  int errors = 0;
  int checks = 0;

  stage_t model = '0;
  stage_t expq[$];
  int     modelCnt = 0;
  int     cntq[$];

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(idv.valid), .id_ctrl(idv.ctrl), .id_ALUOp(idv.aluop),
    .id_funct(idv.funct), .id_rd1(idv.rd1), .id_rd2(idv.rd2),
    .id_imm(idv.imm), .id_rs(idv.rs), .id_rt(idv.rt), .id_rd(idv.rd),
    .id_pc4(idv.pc4),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_ALUOp(ex_ALUOp),
    .ex_funct(ex_funct), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
`ifdef ID_EX_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .ex_pc4(ex_pc4)
  );

  assign actual = {ex_valid, ex_ctrl, ex_ALUOp, ex_funct, ex_rd1, ex_rd2,
                   ex_imm, ex_rs, ex_rt, ex_rd, ex_pc4};

  // Pipeline-stage semantics: a bubble keeps only the data payload, a hold
  // keeps everything, otherwise the ID instruction simply moves to EX.
  function automatic stage_t refNext(stage_t cur, logic s, logic f, stage_t in);
    stage_t n;
    if (f || (!s && !in.valid)) begin
      n       = in;
      n.valid = 1'b0;
      n.ctrl  = '0;
      n.aluop = '0;
      n.rs    = '0;
      n.rt    = '0;
      n.rd    = '0;
    end else if (s) begin
      n = cur;
    end else begin
      n = in;
    end
    return n;
  endfunction

  function automatic stage_t randId(int validPct);
    stage_t r;
    r.valid = ($urandom_range(99) < validPct);
    r.ctrl  = 6'($urandom);
    r.aluop = 2'($urandom);
    r.funct = 6'($urandom);
    r.rd1   = $urandom;
    r.rd2   = $urandom;
    r.imm   = $urandom;
    r.rs    = 5'($urandom);
    r.rt    = 5'($urandom);
    r.rd    = 5'($urandom);
    r.pc4   = $urandom & 32'hFFFF_FFFC;
    return r;
  endfunction

  function automatic stage_t mkInstr(logic [5:0] c, logic [1:0] a, logic [5:0] fn,
                                     logic [31:0] im);
    stage_t r;
    r       = randId(100);
    r.valid = 1'b1;
    r.ctrl  = c;
    r.aluop = a;
    r.funct = fn;
    r.imm   = im;
    return r;
  endfunction

  task automatic checkOutput(string name, stage_t got, stage_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic checkCount(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Drive one cycle of ID/hazard inputs and record what EX must show after
  // the next rising edge.
  task automatic applyStimulus(logic s, logic f, stage_t in);
    @(negedge clk);
    stall = s;
    flush = f;
    idv   = in;
    if (f || (!s && !in.valid)) begin
      if (modelCnt < 65535) modelCnt++;
    end
    model = refNext(model, s, f, in);
    expq.push_back(model);
    cntq.push_back(modelCnt);
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic pulseReset(string name, int edges);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model    = '0;
    modelCnt = 0;
    checkOutput(name, actual, '0);
`ifdef ID_EX_BUBBLE_CNT_EN
    checkCount({name, "_cnt"}, int'(bubble_cnt), 0);
`endif
    repeat (edges) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: one scoreboard entry is due after each rising edge.
  initial begin
    stage_t want;
    int     wantCnt;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        want    = expq.pop_front();
        wantCnt = cntq.pop_front();
        checkOutput("ex_stage", actual, want);
`ifdef ID_EX_BUBBLE_CNT_EN
        checkCount("bubble_cnt", int'(bubble_cnt), wantCnt);
`endif
      end
    end
  end

  // Watchdog in case the stimulus ever stops advancing.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    stage_t lw;
    $display("[TB] start");
    #3;
    checkOutput("reset_initial", actual, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-cycle, then an add lands in EX one edge later.
    applyStimulus(1'b0, 1'b0, randId(100));
    applyStimulus(1'b0, 1'b0, randId(100));
    pulseReset("reset_async", 1);
    applyStimulus(1'b0, 1'b0, mkInstr(6'b100011, 2'b10, 6'b100000, 32'h0));

    // lw held for three stalled cycles while ID keeps changing.
    applyStimulus(1'b0, 1'b0, mkInstr(6'b111010, 2'b00, 6'b000000, 32'h4));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, randId(100));

    // Flush of a sub keeps funct but zeroes control and specifiers.
    applyStimulus(1'b0, 1'b1, mkInstr(6'b100011, 2'b10, 6'b100010, 32'h0));

    // Flush together with stall on a beq loads a bubble rather than holding.
    applyStimulus(1'b0, 1'b0, mkInstr(6'b100011, 2'b10, 6'b100100, 32'h0));
    applyStimulus(1'b1, 1'b1, mkInstr(6'b000000, 2'b01, 6'b000000, 32'h10));

    // Empty ID slot on a load edge vs. while stalled.
    applyStimulus(1'b0, 1'b0, randId(0));
    applyStimulus(1'b0, 1'b0, randId(100));
    applyStimulus(1'b1, 1'b0, randId(0));

    // Reset during a stall with lw held, then a fresh load.
    lw = mkInstr(6'b111010, 2'b00, 6'b000000, 32'h4);
    applyStimulus(1'b0, 1'b0, lw);
    applyStimulus(1'b1, 1'b0, randId(100));
    applyStimulus(1'b1, 1'b0, randId(100));
    stall = 1'b1;
    pulseReset("reset_in_stall", 2);
    applyStimulus(1'b0, 1'b0, randId(100));

    // Random hazard traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(99) < 25, $urandom_range(99) < 15, randId(80));
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    // Counter: 5 flushes and 2 empty loads give 7, then drive to saturation.
    pulseReset("reset_cnt", 1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, randId(100));
    applyStimulus(1'b0, 1'b0, randId(0));
    applyStimulus(1'b1, 1'b0, randId(0));
    applyStimulus(1'b0, 1'b0, randId(0));
    applyStimulus(1'b0, 1'b0, randId(100));
    @(negedge clk);
    checkCount("bubble_cnt_seven", int'(bubble_cnt), 7);
    while (modelCnt < 65534) applyStimulus(1'b0, 1'b1, randId(100));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, randId(100));
    @(negedge clk);
    checkCount("bubble_cnt_sat", int'(bubble_cnt), 65535);
`endif

    // Let the monitor drain, with a bounded wait.
    for (int i = 0; i < 5 && expq.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: pending %0d want 0", expq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
